codec_cfg_sequencer: RTL and testbench
======================================

Name: codec_cfg_sequencer

Overview:
Upstream feeder for the I2C write engine. It walks a fixed table of WM8731 audio-codec register writes and, for each entry, presents chip address plus two data bytes to the I2C engine. It then launches the transfer and waits for completion and ACK status. It reports overall configuration done or error to the top level (DE10-Standard audio path bring-up).

Parameters:
NUM_REGS, 11, number of table entries issued (index 0..NUM_REGS-1)
CHIP_ADDR, 8'h34, 8-bit I2C write address of the codec
GAP_CYCLES, 16'd1000, idle clk cycles between consecutive transfers
TIMEOUT_CYCLES, 20'd500000, max clk cycles waiting for i2c_done before failure
MAX_RETRY, 3, retries per entry (used only with the optional feature)

Ports:
clk  in  1  system clock, all state updates on rising edge
KEY  in  1  asynchronous active-low reset
go  in  1  level/pulse; sampled in IDLE, DONE, ERROR to (re)start the sequence from index 0
i2c_start  out  1  one-cycle pulse launching one 3-byte I2C write
i2c_dev_addr  out  8  chip address byte, always CHIP_ADDR
i2c_data1  out  8  {reg_addr[6:0], reg_data[8]}
i2c_data2  out  8  reg_data[7:0]
i2c_busy  in  1  I2C engine is mid-transfer
i2c_done  in  1  one-cycle pulse at end of transfer (after stop or abort)
i2c_ack_ok  in  1  valid with i2c_done; 1 = all three ACKs received
cfg_index  out  4  table index currently being issued
cfg_done  out  1  sticky: all entries written with ACK
cfg_error  out  1  sticky: NACK or timeout terminated the sequence

Behaviour:
- Reset (KEY=0, async): state IDLE, index 0, counters 0. Outputs: i2c_start=0, i2c_data1/2=0, cfg_done=0, cfg_error=0, cfg_index=0. i2c_dev_addr is constant.
- Table (16-bit word = {reg_addr[6:0], data[8:0]}), index 0..10: 1E00 (R15 reset), 0017, 0217, 0479, 0679, 0812, 0A00, 0C00, 0E01, 1000, 1201 (R9 active last). Indices >= NUM_REGS are never read.
- States:
  - IDLE: go=1 -> LOAD; clears cfg_done and cfg_error.
  - LOAD: registers i2c_data1/2 from table[index]. Next cycle -> ISSUE. Data stays stable until the next LOAD.
  - ISSUE: i2c_start=1 for exactly one cycle; clear timeout counter -> WAIT_DONE.
  - WAIT_DONE: timeout counter increments each cycle.
    - i2c_done with i2c_ack_ok=1 -> GAP.
    - i2c_done with i2c_ack_ok=0 -> ERROR.
    - Counter reaching TIMEOUT_CYCLES-1 without i2c_done -> ERROR.
    - i2c_done and timeout in the same cycle: i2c_done wins.
  - GAP: count GAP_CYCLES cycles. Then if index==NUM_REGS-1 -> DONE, else index+1 -> LOAD.
  - DONE: cfg_done=1; go=1 -> index 0, clear flags, LOAD.
  - ERROR: cfg_error=1; cfg_index holds the failing entry; go=1 -> index 0, clear flags, LOAD.
- go is ignored in LOAD, ISSUE, WAIT_DONE and GAP.
- i2c_done outside WAIT_DONE is ignored.
- i2c_busy is informational. ISSUE is not entered while i2c_busy=1: LOAD stalls until it is 0.
- cfg_done and cfg_error are never both 1.
- Latency: go to first i2c_start = 2 cycles (LOAD, ISSUE) when i2c_busy=0.
- Reset mid-transfer aborts immediately. The I2C engine is on the same KEY and returns to its wait state.

Optional Feature:
CODEC_CFG_RETRY_EN
- Defined: a NACK or timeout in WAIT_DONE with retry count < MAX_RETRY increments the retry count and goes to GAP, then re-enters LOAD with the same index. Retry count clears on successful ACK and on advancing index. ERROR only after MAX_RETRY failed retries (MAX_RETRY+1 attempts).
- Undefined: the first NACK or timeout goes straight to ERROR; no retry counter is synthesized.

Decomposition:
- Shared package codec_cfg_pkg:
  - state enum constants
  - WM8731 register address constants (R0..R9, R15)
  - table word width (16)
  - CHIP_ADDR default
- One natural sub-module: codec_cfg_rom (combinational index -> 16-bit word lookup), reusable by other bring-up sequencers.

Test Plan:
- Happy path: go pulse, bench ACKs every transfer. Expect:
  - exactly 11 i2c_start pulses in order with data1/data2 = 1E/00, 00/17 … 12/01
  - cfg_done=1, cfg_index=10
  - gaps of at least GAP_CYCLES
- NACK on index 3 (ack_ok=0), feature off: cfg_error=1, cfg_index=3, no further i2c_start. Second go restarts at index 0 with data 1E/00.
- Timeout: bench never pulses i2c_done at index 0. cfg_error=1 exactly TIMEOUT_CYCLES cycles after ISSUE; i2c_done on that same cycle with ack_ok=1 -> GAP instead.
- With CODEC_CFG_RETRY_EN, MAX_RETRY=3: index 5 NACKs twice then ACKs. Index 5 issued 3 times, sequence completes with cfg_done=1. NACK 4 times -> cfg_error at index 5.
- KEY asserted during WAIT_DONE of index 6: all outputs zero immediately. After release and go, the sequence restarts at index 0.
- go held high continuously plus spurious i2c_done during GAP: no extra i2c_start, no double index advance, no restart until DONE.

Source files
------------

// File: rtl/codec_cfg_pkg.sv
// codec_cfg_pkg: shared types and constants for codec bring-up sequencers.
// Holds the FSM state enum, WM8731 register addresses, word width and chip address.
package codec_cfg_pkg;

  localparam int unsigned WORD_W = 16;
  localparam logic [7:0] CHIP_ADDR_DEF = 8'h34;

  localparam logic [6:0] R0_LLINE  = 7'h00;
  localparam logic [6:0] R1_RLINE  = 7'h01;
  localparam logic [6:0] R2_LHP    = 7'h02;
  localparam logic [6:0] R3_RHP    = 7'h03;
  localparam logic [6:0] R4_APATH  = 7'h04;
  localparam logic [6:0] R5_DPATH  = 7'h05;
  localparam logic [6:0] R6_PWR    = 7'h06;
  localparam logic [6:0] R7_IFACE  = 7'h07;
  localparam logic [6:0] R8_SRATE  = 7'h08;
  localparam logic [6:0] R9_ACTIVE = 7'h09;
  localparam logic [6:0] R15_RESET = 7'h0F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_GAP,
    S_DONE,
    S_ERROR
  } state_t;

  function automatic logic [WORD_W-1:0] cfg_word(
    input logic [6:0] addr,
    input logic [8:0] data
  );
    return {addr, data};
  endfunction

endpackage

// File: rtl/codec_cfg_rom.sv
// codec_cfg_rom: combinational WM8731 bring-up table, index -> {addr[6:0], data[8:0]}.
// Ports: index (table entry), word (16-bit register write); unused indices read 0.
module codec_cfg_rom
  import codec_cfg_pkg::*;
(
  input  logic [3:0]        index,
  output logic [WORD_W-1:0] word
);

  always_comb begin
    word = '0;
    case (index)
      4'd0:    word = cfg_word(R15_RESET, 9'h000);
      4'd1:    word = cfg_word(R0_LLINE,  9'h017);
      4'd2:    word = cfg_word(R1_RLINE,  9'h017);
      4'd3:    word = cfg_word(R2_LHP,    9'h079);
      4'd4:    word = cfg_word(R3_RHP,    9'h079);
      4'd5:    word = cfg_word(R4_APATH,  9'h012);
      4'd6:    word = cfg_word(R5_DPATH,  9'h000);
      4'd7:    word = cfg_word(R6_PWR,    9'h000);
      4'd8:    word = cfg_word(R7_IFACE,  9'h001);
      4'd9:    word = cfg_word(R8_SRATE,  9'h000);
      4'd10:   word = cfg_word(R9_ACTIVE, 9'h001);
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/codec_cfg_sequencer.sv
// codec_cfg_sequencer: walks the WM8731 table, issuing one 3-byte I2C write per entry.
// Ports: clk, KEY (async low reset), go; i2c_start/dev_addr/data1/data2 out,
// i2c_busy/done/ack_ok in; cfg_index, cfg_done, cfg_error status.
// Build option: CODEC_CFG_RETRY_EN adds per-entry retries on NACK/timeout.
module codec_cfg_sequencer
  import codec_cfg_pkg::*;
#(
`ifdef CODEC_CFG_RETRY_EN
  parameter int unsigned  MAX_RETRY      = 3,
`endif
  parameter int unsigned  NUM_REGS       = 11,
  parameter logic [7:0]   CHIP_ADDR      = CHIP_ADDR_DEF,
  parameter logic [15:0]  GAP_CYCLES     = 16'd1000,
  parameter logic [19:0]  TIMEOUT_CYCLES = 20'd500000
) (
  input  logic       clk,
  input  logic       KEY,
  input  logic       go,
  output logic       i2c_start,
  output logic [7:0] i2c_dev_addr,
  output logic [7:0] i2c_data1,
  output logic [7:0] i2c_data2,
  input  logic       i2c_busy,
  input  logic       i2c_done,
  input  logic       i2c_ack_ok,
  output logic [3:0] cfg_index,
  output logic       cfg_done,
  output logic       cfg_error
);

  localparam logic [3:0] LAST = 4'(NUM_REGS - 1);

  state_t state, state_n;
  logic [3:0]        idx;
  logic [7:0]        d1, d2;
  logic [19:0]       tcnt;
  logic [15:0]       gcnt;
  logic [WORD_W-1:0] word;
  logic              t_exp, gap_end, ack, fail;
  logic              again, can_retry;
  logic              restart, ld, idx_inc;

  codec_cfg_rom u_rom (
    .index(idx),
    .word (word)
  );

  assign t_exp   = (tcnt == TIMEOUT_CYCLES - 20'd1);
  assign gap_end = ({1'b0, gcnt} + 17'd1) >= {1'b0, GAP_CYCLES};
  assign ack     = i2c_done & i2c_ack_ok;
  // a done pulse overrides a coincident timeout
  assign fail    = i2c_done ? ~i2c_ack_ok : t_exp;

`ifdef CODEC_CFG_RETRY_EN
  localparam logic [3:0] MAX_R = 4'(MAX_RETRY);
  logic [3:0] rcnt;

  assign can_retry = (rcnt < MAX_R);
  // nonzero count in GAP means this gap follows a failure: redo same entry
  assign again     = (rcnt != 4'd0);

  always_ff @(posedge clk or negedge KEY) begin
    if (!KEY) begin
      rcnt <= '0;
    end else if (restart || (state == S_WAIT && ack)) begin
      rcnt <= '0;
    end else if (state == S_WAIT && fail && can_retry) begin
      rcnt <= rcnt + 4'd1;
    end
  end
`else
  assign can_retry = 1'b0;
  assign again     = 1'b0;
`endif

  always_comb begin
    state_n = state;
    restart = 1'b0;
    ld      = 1'b0;
    idx_inc = 1'b0;
    unique case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (go) begin
          restart = 1'b1;
          state_n = S_LOAD;
        end
      end
      S_LOAD: begin
        ld = 1'b1;
        if (!i2c_busy) state_n = S_ISSUE;
      end
      S_ISSUE: state_n = S_WAIT;
      S_WAIT: begin
        if (ack) state_n = S_GAP;
        else if (fail) state_n = can_retry ? S_GAP : S_ERROR;
      end
      S_GAP: begin
        if (gap_end) begin
          if (again) begin
            state_n = S_LOAD;
          end else if (idx == LAST) begin
            state_n = S_DONE;
          end else begin
            idx_inc = 1'b1;
            state_n = S_LOAD;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge KEY) begin
    if (!KEY) begin
      state <= S_IDLE;
      idx   <= '0;
      d1    <= '0;
      d2    <= '0;
      tcnt  <= '0;
      gcnt  <= '0;
    end else begin
      state <= state_n;
      if (restart) idx <= '0;
      else if (idx_inc) idx <= idx + 4'd1;
      if (ld) begin
        d1 <= word[15:8];
        d2 <= word[7:0];
      end
      tcnt <= (state == S_WAIT) ? tcnt + 20'd1 : 20'd0;
      gcnt <= (state == S_GAP) ? gcnt + 16'd1 : 16'd0;
    end
  end

  assign i2c_start    = (state == S_ISSUE);
  assign i2c_dev_addr = CHIP_ADDR;
  assign i2c_data1    = d1;
  assign i2c_data2    = d2;
  assign cfg_index    = idx;
  assign cfg_done     = (state == S_DONE);
  assign cfg_error    = (state == S_ERROR);

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// tb_codec_cfg_sequencer: scoreboard bench for codec_cfg_sequencer.
// Expected transfers are queued by stimulus; a monitor checks each i2c_start.
module tb_codec_cfg_sequencer;

  localparam int G = 20;
  localparam int T = 100;

  typedef struct {
    bit send;
    int dly;
    bit ack;
  } resp_t;

  logic       clk = 1'b0;
  logic       KEY = 1'b1;
  logic       go = 1'b0;
  logic       i2c_busy = 1'b0;
  logic       i2c_done = 1'b0;
  logic       i2c_ack_ok = 1'b0;
  logic       i2c_start;
  logic [7:0] i2c_dev_addr, i2c_data1, i2c_data2;
  logic [3:0] cfg_index;
  logic       cfg_done, cfg_error;

  logic [15:0] tbl [11] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479,
                            16'h0679, 16'h0812, 16'h0A00, 16'h0C00,
                            16'h0E01, 16'h1000, 16'h1201};

  int    eq[$];
  resp_t rq[$];
  int    pass_n = 0;
  int    tot_n = 0;
  int    n_start = 0;
  int    cyc = 0;
  int    last_start_cyc = 0;
  int    last_done_cyc = -1000000;
  bit    spur_def = 1'b0;

  codec_cfg_sequencer #(
    .NUM_REGS      (11),
    .CHIP_ADDR     (8'h34),
    .GAP_CYCLES    (16'(G)),
    .TIMEOUT_CYCLES(20'(T))
  ) dut (
    .clk         (clk),
    .KEY         (KEY),
    .go          (go),
    .i2c_start   (i2c_start),
    .i2c_dev_addr(i2c_dev_addr),
    .i2c_data1   (i2c_data1),
    .i2c_data2   (i2c_data2),
    .i2c_busy    (i2c_busy),
    .i2c_done    (i2c_done),
    .i2c_ack_ok  (i2c_ack_ok),
    .cfg_index   (cfg_index),
    .cfg_done    (cfg_done),
    .cfg_error   (cfg_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    tot_n++;
    if (act == req) pass_n++;
    else $display("FAIL %s: got %0h want %0h", nm, act, req);
  endtask

  task automatic push_exp(input int a, input int b);
    for (int i = a; i <= b; i++) eq.push_back(i);
  endtask

  task automatic push_resp(input bit send, input int dly, input bit ack);
    resp_t r;
    r.send = send;
    r.dly = dly;
    r.ack = ack;
    rq.push_back(r);
  endtask

  task automatic pulse_go();
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_end(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cfg_done && !cfg_error && n < 5000);
    if (!cfg_done && !cfg_error) begin
      tot_n++;
      $display("FAIL %s: no done/error within 5000 cycles", nm);
    end
  endtask

  // monitor: every start must match the head of the expected queue
  initial forever begin
    int e;
    @(negedge clk);
    if (i2c_start) begin
      if (eq.size() == 0) begin
        tot_n++;
        $display("FAIL unexpected_start: got idx %0d want none", cfg_index);
      end else begin
        e = eq.pop_front();
        chk("start_word", {i2c_dev_addr, i2c_data1, i2c_data2, cfg_index},
            {8'h34, tbl[e], 4'(e)});
        if (e != 0) chk("gap_len_ok", int'((cyc - last_done_cyc) > G), 1);
      end
      last_start_cyc = cyc;
      n_start++;
    end
  end

  // I2C engine model: done pulse dly cycles after the start cycle
  initial begin
    int pend, spur;
    bit p_ack;
    resp_t r;
    pend = -1;
    spur = -1;
    p_ack = 1'b0;
    forever begin
      @(negedge clk);
      i2c_done = 1'b0;
      i2c_ack_ok = 1'b0;
      if (!KEY) begin
        pend = -1;
        spur = -1;
        i2c_busy = 1'b0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            i2c_done = 1'b1;
            i2c_ack_ok = p_ack;
            i2c_busy = 1'b0;
            last_done_cyc = cyc;
            pend = -1;
            if (spur_def) spur = 3;
          end
        end else if (spur > 0) begin
          spur--;
          if (spur == 0) begin
            i2c_done = 1'b1;
            i2c_ack_ok = 1'b1;
            spur = -1;
          end
        end
        if (i2c_start) begin
          if (rq.size() != 0) r = rq.pop_front();
          else begin
            r.send = 1'b1;
            r.dly = 4;
            r.ack = 1'b1;
          end
          if (r.send) begin
            pend = r.dly;
            p_ack = r.ack;
            i2c_busy = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n;
    #2 KEY = 1'b0;
    #1;
    chk("rst_start", i2c_start, 0);
    chk("rst_data1", i2c_data1, 0);
    chk("rst_data2", i2c_data2, 0);
    chk("rst_done", cfg_done, 0);
    chk("rst_error", cfg_error, 0);
    chk("rst_index", cfg_index, 0);
    chk("rst_devaddr", i2c_dev_addr, 8'h34);
    repeat (2) @(negedge clk);
    KEY = 1'b1;

    // happy path, go -> start latency of 2 cycles
    push_exp(0, 10);
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    chk("go_latency_start", i2c_start, 1);
    wait_end("happy");
    chk("happy_done", cfg_done, 1);
    chk("happy_error", cfg_error, 0);
    chk("happy_index", cfg_index, 10);
    chk("happy_all_issued", eq.size(), 0);

`ifdef CODEC_CFG_RETRY_EN
    // index 5 NACKs twice, then ACKs
    push_exp(0, 5);
    push_exp(5, 5);
    push_exp(5, 10);
    for (int i = 0; i < 5; i++) push_resp(1, 4, 1);
    push_resp(1, 4, 0);
    push_resp(1, 4, 0);
    pulse_go();
    wait_end("retry_ok");
    chk("retry_ok_done", cfg_done, 1);
    chk("retry_ok_index", cfg_index, 10);
    // index 5 NACKs on all four attempts
    push_exp(0, 5);
    for (int i = 0; i < 3; i++) eq.push_back(5);
    for (int i = 0; i < 5; i++) push_resp(1, 4, 1);
    for (int i = 0; i < 4; i++) push_resp(1, 4, 0);
    pulse_go();
    wait_end("retry_fail");
    chk("retry_fail_error", cfg_error, 1);
    chk("retry_fail_done", cfg_done, 0);
    chk("retry_fail_index", cfg_index, 5);
`else
    // NACK on index 3 stops the sequence
    push_exp(0, 3);
    for (int i = 0; i < 3; i++) push_resp(1, 4, 1);
    push_resp(1, 4, 0);
    pulse_go();
    wait_end("nack");
    chk("nack_error", cfg_error, 1);
    chk("nack_done", cfg_done, 0);
    chk("nack_index", cfg_index, 3);
`endif
    repeat (3 * G) @(negedge clk);
    chk("fail_no_more_starts", eq.size(), 0);

    // restart after error begins again at index 0
    push_exp(0, 10);
    pulse_go();
    wait_end("restart");
    chk("restart_done", cfg_done, 1);
    chk("restart_index", cfg_index, 10);

    // timeout: no done ever arrives for index 0
`ifdef CODEC_CFG_RETRY_EN
    for (int i = 0; i < 4; i++) begin
      eq.push_back(0);
      push_resp(0, 0, 0);
    end
`else
    push_exp(0, 0);
    push_resp(0, 0, 0);
`endif
    pulse_go();
    wait_end("timeout");
    chk("timeout_error", cfg_error, 1);
    chk("timeout_index", cfg_index, 0);
    // wait cycles strictly between the ISSUE cycle and the ERROR cycle
    chk("timeout_cycles", cyc - last_start_cyc - 1, T);

    // done arriving on the timeout cycle wins
    push_exp(0, 10);
    push_resp(1, T, 1);
    pulse_go();
    wait_end("tie");
    chk("tie_done", cfg_done, 1);
    chk("tie_error", cfg_error, 0);

    // go held high with spurious done pulses during every GAP
    spur_def = 1'b1;
    push_exp(0, 10);
    @(negedge clk);
    go = 1'b1;
    wait_end("go_held");
    go = 1'b0;
    chk("go_held_done", cfg_done, 1);
    chk("go_held_index", cfg_index, 10);
    spur_def = 1'b0;
    repeat (5) @(negedge clk);
    chk("go_held_no_restart", cfg_done, 1);
    chk("go_held_all_issued", eq.size(), 0);

    // reset during WAIT_DONE of index 6
    base = n_start;
    push_exp(0, 6);
    for (int i = 0; i < 6; i++) push_resp(1, 4, 1);
    push_resp(0, 0, 0);
    pulse_go();
    n = 0;
    while (n_start < base + 7 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_index6", n_start - base, 7);
    repeat (5) @(negedge clk);
    KEY = 1'b0;
    #1;
    chk("mid_rst_start", i2c_start, 0);
    chk("mid_rst_data", {i2c_data1, i2c_data2}, 0);
    chk("mid_rst_index", cfg_index, 0);
    chk("mid_rst_flags", {cfg_done, cfg_error}, 0);
    repeat (2) @(negedge clk);
    KEY = 1'b1;
    push_exp(0, 10);
    pulse_go();
    wait_end("post_reset");
    chk("post_reset_done", cfg_done, 1);
    chk("post_reset_index", cfg_index, 10);

    chk("exp_queue_empty", eq.size(), 0);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule
